// File: rtl/programmable_info_frame_pkg.sv
// Shared types and address map for the programmable HDMI InfoFrame source.
// The byte walk order of the checksum engine matches the host address map.
`timescale 1ns/1ps
package hdmi_infoframe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUM     = 2'd1,
        PUBLISH = 2'd2
    } info_state_t;

    localparam logic [4:0] ADDR_TYPE    = 5'd0;
    localparam logic [4:0] ADDR_VERSION = 5'd1;
    localparam logic [4:0] ADDR_LENGTH  = 5'd2;
    localparam logic [4:0] ADDR_PB_BASE = 5'd2;

    localparam int MAX_PB = 27;

endpackage

// File: rtl/programmable_info_frame_checksum_engine.sv
// Serial mod-256 accumulator: after i_start it adds one byte per cycle for
// NUM_BYTES cycles, presenting the index of the byte it wants next.
`timescale 1ns/1ps
module infoframe_checksum_engine #(
    parameter int NUM_BYTES = 30
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic [4:0] o_idx,
    output logic       o_last,
    output logic [7:0] o_acc
);

    logic       r_active;
    logic [4:0] r_idx;
    logic [7:0] r_acc;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_idx    <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_idx    <= '0;
            r_acc    <= '0;
        end else if (r_active) begin
            r_acc <= r_acc + i_byte;
            r_idx <= r_idx + 5'd1;
            if (o_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_last = r_active && (r_idx == 5'(NUM_BYTES - 1));
    assign o_idx  = r_idx;
    assign o_acc  = r_acc;

endmodule

// File: rtl/programmable_info_frame.sv
// Runtime-programmable InfoFrame source: host-written shadow buffer, serial
// checksum, and tear-free publication into the active header/sub registers.
`timescale 1ns/1ps
module programmable_info_frame
    import hdmi_infoframe_pkg::*;
#(
    parameter int         MAX_PAYLOAD     = 27,
    parameter logic [7:0] DEFAULT_TYPE    = 8'h83,
    parameter logic [7:0] DEFAULT_VERSION = 8'h01,
    parameter logic [4:0] DEFAULT_LENGTH  = 5'd25
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             commit,
    input  logic             packet_in_use,
    output logic             busy,
    output logic             wr_error,
    output logic             publish_done,
    output logic             frame_valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);

    localparam logic [4:0] MAX_LEN = 5'(MAX_PAYLOAD);

    info_state_t     r_state;
    logic            r_busy;
    logic            r_wr_error;
    logic            r_publish_done;
    logic            r_frame_valid;
    logic [23:0]     r_header;
    logic [3:0][55:0] r_sub;

    logic [7:0]      r_type;
    logic [7:0]      r_version;
    logic [4:0]      r_length;
    logic [7:0]      r_pb [1:MAX_PB];

    logic            w_start;
    logic [4:0]      w_idx;
    logic            w_last;
    logic [7:0]      w_acc;
    logic [7:0]      w_byte;
    logic [4:0]      w_wr_pb_idx;
    logic [4:0]      w_rd_pb_idx;
    logic [7:0]      w_pub_bytes [0:MAX_PB];
    logic [3:0][55:0] w_pub_sub;

    assign w_start     = (r_state == IDLE) && commit;
    assign w_wr_pb_idx = wr_addr - ADDR_PB_BASE;
    assign w_rd_pb_idx = w_idx - ADDR_PB_BASE;

    // Shadow writes only land in IDLE, so a same-cycle commit sums the new value.
    // NOTE: the payload array is reset because the cleared payload is visible
    // behaviour here; a plain data RAM would normally be left without reset.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_type    <= DEFAULT_TYPE;
            r_version <= DEFAULT_VERSION;
            r_length  <= DEFAULT_LENGTH;
            for (int i = 1; i <= MAX_PB; i++) begin
                r_pb[i] <= 8'h00;
            end
        end else if (wr_en && (r_state == IDLE)) begin
            case (wr_addr)
                ADDR_TYPE:    r_type    <= wr_data;
                ADDR_VERSION: r_version <= wr_data;
                ADDR_LENGTH:  r_length  <= (wr_data[4:0] > MAX_LEN) ? MAX_LEN : wr_data[4:0];
                default: begin
                    if (w_wr_pb_idx <= MAX_LEN) begin
                        r_pb[w_wr_pb_idx] <= wr_data;
                    end
                end
            endcase
        end
    end

    // NOTE: every variable driven here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_byte = 8'h00;
        case (w_idx)
            ADDR_TYPE:    w_byte = r_type;
            ADDR_VERSION: w_byte = r_version;
            ADDR_LENGTH:  w_byte = {3'b000, r_length};
            default: begin
                if (w_rd_pb_idx <= r_length) begin
                    w_byte = r_pb[w_rd_pb_idx];
                end
            end
        endcase
    end

    // Publication image: bytes past the programmed length are forced to zero.
    always_comb begin
        w_pub_sub      = '0;
        w_pub_bytes[0] = 8'h00 - w_acc;
        for (int i = 1; i <= MAX_PB; i++) begin
            w_pub_bytes[i] = (i <= int'(r_length)) ? r_pb[i] : 8'h00;
        end
        for (int i = 0; i <= MAX_PB; i++) begin
            w_pub_sub[i / 7][8 * (i % 7) +: 8] = w_pub_bytes[i];
        end
    end

    infoframe_checksum_engine #(
        .NUM_BYTES (3 + MAX_PAYLOAD)
    ) u_checksum (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .i_start   (w_start),
        .i_byte    (w_byte),
        .o_idx     (w_idx),
        .o_last    (w_last),
        .o_acc     (w_acc)
    );

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_wr_error     <= 1'b0;
            r_publish_done <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_header       <= '0;
            r_sub          <= '0;
        end else begin
            r_wr_error     <= (r_state != IDLE) && (wr_en || commit);
            r_publish_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (commit) begin
                        r_state <= SUM;
                        r_busy  <= 1'b1;
                    end
                end
                SUM: begin
                    if (w_last) begin
                        r_state <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    // Hold off while the assembler is mid-packet to avoid tearing.
                    if (!packet_in_use) begin
                        r_header       <= {3'b000, r_length, r_version, r_type};
                        r_sub          <= w_pub_sub;
                        r_frame_valid  <= 1'b1;
                        r_publish_done <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign wr_error     = r_wr_error;
    assign publish_done = r_publish_done;
    assign frame_valid  = r_frame_valid;
    assign header       = r_header;
    assign sub          = r_sub;

endmodule

// File: doc/programmable_info_frame.md
Name: programmable_info_frame

Overview:
Runtime-programmable HDMI InfoFrame packet source, the generalised successor to fixed-parameter InfoFrame blocks such as SPD. A host writes the type, version, length and payload bytes into a shadow buffer, then pulses commit. A sequential checksum engine walks the shadow buffer and computes PB0. The result is published atomically to the active buffer that drives header/sub into the packet assembler, and publication never tears a packet mid-transmission.

Parameters:
MAX_PAYLOAD, 27, highest payload byte index PBn held (1..27); storage is PB0..PB27, and bytes above MAX_PAYLOAD always read 0.
DEFAULT_TYPE, 8'h83, shadow type byte after reset (bit7 included as written).
DEFAULT_VERSION, 8'h01, shadow version byte after reset.
DEFAULT_LENGTH, 5'd25, shadow length after reset.

Ports:
clk_pixel  in  1  pixel clock; all logic in this domain.
reset_n  in  1  asynchronous, active-low reset.
wr_en  in  1  shadow write strobe.
wr_addr  in  5  0=type, 1=version, 2=length, 3..29 = PB1..PB27 (addr-2); 30,31 ignored.
wr_data  in  8  write data.
commit  in  1  single-cycle request to checksum and publish the shadow buffer.
packet_in_use  in  1  high while the assembler is serialising the current InfoFrame; publication is blocked.
busy  out  1  high in SUM or PUBLISH.
wr_error  out  1  one-cycle pulse: wr_en or commit arrived while busy (request discarded).
publish_done  out  1  one-cycle pulse in the cycle the active buffer is updated.
frame_valid  out  1  0 until the first publish, then 1.
header  out  24  {3'b0,length}, version, type from the active buffer.
sub  out  4x56  sub[i] = {PB(6+7i),...,PB(7i)} from the active buffer, little-endian byte order.

Behaviour:
- Reset (async assert, sync release):
  - Shadow: type/version/length = defaults; payload = 0.
  - Active buffer, header, sub: all 0.
  - frame_valid, busy, wr_error, publish_done: 0.
  - FSM to IDLE.
  - Reset mid-SUM/PUBLISH aborts with no partial publish.
- Length write: stored value = min(wr_data[4:0], MAX_PAYLOAD); wr_data[7:5] discarded.
- Writes in IDLE update the shadow on the next edge. Writes to PB indices > MAX_PAYLOAD are dropped silently.
- FSM states: IDLE, SUM, PUBLISH.
  - IDLE: commit=1 -> SUM with acc=0, idx=0. If wr_en and commit arrive in the same cycle, the write lands first and is included in the sum.
  - SUM: one byte per cycle in the order type, version, length, PB1..PB(MAX_PAYLOAD); fixed 3+MAX_PAYLOAD cycles. Bytes with index > length contribute 0 and are zeroed in the published copy. After the last byte -> PUBLISH.
  - PUBLISH: waits while packet_in_use=1. On the first cycle with packet_in_use=0:
    - PB0 = (8'h00 - acc) mod 256;
    - active buffer <= masked shadow plus PB0;
    - frame_valid <= 1; publish_done pulses; next state IDLE.
- Arithmetic: 8-bit accumulator, wraps mod 256. Invariant: type + version + {3'b0,length} + PB0 + ... + PB(length) == 8'h00.
- Latency: commit at edge t -> header/sub change at edge t+4+MAX_PAYLOAD, when packet_in_use stays low.
- While busy: wr_en or commit -> wr_error pulse, request dropped, shadow unchanged.
- Outputs are registered with no combinational path from any input. Active-buffer outputs are stable between publishes.

Decomposition:
- Package hdmi_infoframe_pkg:
  - typedef info_state_t {IDLE, SUM, PUBLISH};
  - address constants ADDR_TYPE=0, ADDR_VERSION=1, ADDR_LENGTH=2, ADDR_PB_BASE=2;
  - localparam MAX_PB=27.
- One sub-module, infoframe_checksum_engine: serial accumulator and index counter with start/done. The parent keeps the buffers, the FSM and the host interface.

Test Plan:
- Reset, no writes -> frame_valid=0, header=0, sub[0..3]=0; busy=0.
- SPD: type 83, version 01, length 19, PB1=41, rest 0; commit -> after 31 cycles publish_done; header=24'h190183; sub[0][15:0]=16'h4122 (PB0=22).
- AVI: type 82, version 02, length 0D, zero payload -> PB0=6F; header=24'h0D0282. Also write PB20=FF with length 0D -> published PB20=00, PB0 still 6F.
- Length write 8'hFF (MAX_PAYLOAD=27) -> header[23:16]=1B; checksum covers PB1..PB27.
- packet_in_use held high for 100 cycles after SUM completes -> busy stays 1, outputs unchanged, publish_done exactly 1 cycle after packet_in_use falls.
- wr_en and commit during SUM -> wr_error pulses, published data reflects the pre-commit shadow. Assert reset_n mid-SUM -> all outputs 0, frame_valid=0.
